count_match_timer: RTL
======================

Name: count_match_timer

Overview:
- Downstream consumer of the free-running 8-bit tick counter: samples its count output every newclk_k cycle and accumulates elapsed ticks into a wider register.
- Elapsed ticks are accumulated across counter wrap-around, and across counter resets only where those are detected (see Behaviour).
- Fires a one-cycle trig pulse when the elapsed count reaches a programmed target (timer_in).
- Supports one-shot and periodic modes; feeds event/trigger logic further downstream.

Parameters:
- CW, 8, width of the upstream count bus.
- TW, 16, width of target, elapsed accumulator and timer_in.
- FCW, 8, width of the saturating fire counter.

Ports:
- newclk_k  in  1  clock; same clock as the upstream counter.
- rstn  in  1  asynchronous active-low reset.
- count_in  in  CW  upstream counter value.
- timer_in  in  TW  target tick count; sampled only on an accepted start.
- start  in  1  single-cycle request to load the target and begin timing.
- stop  in  1  abort timing and return to IDLE.
- periodic  in  1  sampled on start: 1 = reload and keep running after fire; 0 = one-shot.
- trig  out  1  one-cycle pulse on target reached.
- busy  out  1  high in RUN.
- done  out  1  high in DONE (one-shot completed).
- err  out  1  one-cycle pulse when start is given with timer_in == 0.
- elapsed  out  TW  current accumulated ticks.
- fire_cnt  out  FCW  number of trig pulses since the last accepted start; saturates at all-ones.

Behaviour:
- Reset (async on rstn low, released synchronously to newclk_k):
  - state = IDLE; prev_cnt = 0; target = 0.
  - trig, busy, done, err = 0; elapsed = 0; fire_cnt = 0.
- Delta computation (every cycle, all states), with prev_cnt <= count_in every cycle:
  - delta = (count_in - prev_cnt) mod 2^CW.
  - Exception: if count_in == 0 and prev_cnt != all-ones, delta = 0. This treats an upstream reset as a resync, not as a near-full wrap.
- State IDLE:
  - On start with timer_in != 0: target <= timer_in; mode <= periodic; elapsed <= 0; fire_cnt <= 0; go to RUN.
  - On start with timer_in == 0: err = 1 for one cycle; stay in IDLE; all other registers unchanged.
- State RUN:
  - Each cycle: sum = elapsed + delta, computed at TW+1 bits (no overflow loss).
  - If sum >= target:
    - trig = 1 next cycle; fire_cnt += 1 (saturating).
    - mode periodic: elapsed <= sum - target; stay in RUN.
    - mode one-shot: elapsed <= target; go to DONE.
  - Otherwise: elapsed <= sum.
- State DONE:
  - done = 1; elapsed is held.
  - start behaves as in IDLE (reload, or err on a zero target).
- Stop, from any state: next state IDLE, elapsed held, done cleared, no trig.
- Priority order: rstn > stop > start > accumulate/fire.
  - start and stop in the same cycle: stop wins; the start is ignored.
  - start in RUN: restart; the target is reloaded and elapsed is cleared. A fire condition in that same cycle is discarded (no trig).
- Pulse rules:
  - trig is registered: it is high in the cycle after the count_in sample that makes sum >= target.
  - trig is never high on two consecutive cycles unless a periodic target is <= delta.
  - Multiple target crossings within one large delta produce exactly one trig.
- timer_in changes while busy have no effect until the next accepted start.
- busy, done and err are all registered outputs.

Test Plan:
- Reset mid-RUN: elapsed=5 at the moment rstn drops -> all outputs 0 immediately (asynchronously, without a clock edge); after release, state IDLE and a start is required.
- One-shot run: count_in increments by 1 per cycle from 0, timer_in=10, start -> trig high exactly once, 10 cycles after the first post-start sample; done=1; elapsed=10; busy=0; fire_cnt=1.
- Periodic across wrap: count_in runs 250..255,0..9, timer_in=6, periodic=1 -> trig every 6 ticks across the 255->0 wrap; 16 ticks in total give fire_cnt=2 and elapsed=4.
- Upstream reset resync: count_in goes 40 -> 0 mid-RUN -> delta=0 that cycle; elapsed unchanged; counting resumes from 0 with no spurious trig.
- Zero target and priority cases:
  - start with timer_in=0 -> err pulse, state stays IDLE.
  - start and stop together in RUN -> IDLE, no trig.
  - start in RUN on a would-fire cycle -> restart with no trig.
- Saturation: periodic mode with timer_in=1 for 300 ticks -> fire_cnt holds at 255, and trig continues to pulse every tick.

Source files
------------

// File: rtl/count_match_timer.sv
// Accumulates elapsed ticks from a free-running upstream counter
// and pulses trig when a programmed target is reached.
module count_match_timer #(
    parameter int CW  = 8,
    parameter int TW  = 16,
    parameter int FCW = 8
) (
    input  logic           newclk_k,
    input  logic           rstn,
    input  logic [CW-1:0]  count_in,
    input  logic [TW-1:0]  timer_in,
    input  logic           start,
    input  logic           stop,
    input  logic           periodic,
    output logic           trig,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic [TW-1:0]  elapsed,
    output logic [FCW-1:0] fire_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state;
    state_t         state_n;
    logic [CW-1:0]  prev_cnt;
    logic [TW-1:0]  target;
    logic [TW-1:0]  target_n;
    logic           mode;
    logic           mode_n;
    logic [TW-1:0]  elapsed_n;
    logic [FCW-1:0] fire_n;
    logic           trig_n;
    logic           err_n;
    logic [CW-1:0]  delta;
    logic [TW:0]    sum;
    logic           load;
    logic           zerr;

    // A drop to zero from anything but all-ones is an upstream reset.
    always_comb begin
        delta = count_in - prev_cnt;
        if (count_in == '0 && prev_cnt != '1)
            delta = '0;
    end

    assign sum  = {1'b0, elapsed} + {{(TW + 1 - CW){1'b0}}, delta};
    assign load = !stop && start && (timer_in != '0);
    assign zerr = !stop && start && (timer_in == '0);

    always_comb begin
        state_n   = state;
        target_n  = target;
        mode_n    = mode;
        elapsed_n = elapsed;
        fire_n    = fire_cnt;
        trig_n    = 1'b0;
        err_n     = 1'b0;
        if (stop) begin
            state_n = IDLE;
        end else if (load) begin
            state_n   = RUN;
            target_n  = timer_in;
            mode_n    = periodic;
            elapsed_n = '0;
            fire_n    = '0;
        end else begin
            err_n = zerr;
            unique case (state)
                RUN: begin
                    if (sum >= {1'b0, target}) begin
                        trig_n = 1'b1;
                        if (fire_cnt != '1)
                            fire_n = fire_cnt + 1'b1;
                        if (mode) begin
                            elapsed_n = TW'(sum - {1'b0, target});
                        end else begin
                            elapsed_n = target;
                            state_n   = DONE;
                        end
                    end else begin
                        elapsed_n = sum[TW-1:0];
                    end
                end
                IDLE, DONE: begin
                    state_n = state;
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge newclk_k or negedge rstn) begin
        if (!rstn) begin
            state    <= IDLE;
            prev_cnt <= '0;
            target   <= '0;
            mode     <= 1'b0;
            elapsed  <= '0;
            fire_cnt <= '0;
            trig     <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            state    <= state_n;
            prev_cnt <= count_in;
            target   <= target_n;
            mode     <= mode_n;
            elapsed  <= elapsed_n;
            fire_cnt <= fire_n;
            trig     <= trig_n;
            busy     <= (state_n == RUN);
            done     <= (state_n == DONE);
            err      <= err_n;
        end
    end

endmodule
